// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with a memory-ready timeout.
// Define MC_CTRL_IMM_EN to decode addi/andi through IEXE/IWB.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_eq,
  output logic             pc_write_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             bus_err,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WCW = $clog2(TIMEOUT);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CTRL_IMM_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
`endif

  localparam logic [WCW-1:0]   WAIT_MAX = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]   WAIT_ONE = WCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REXE  = 4'd6,
    S_RWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_IEXE  = 4'd10,
    S_IWB   = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout;
  logic             retire;
  logic             illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    illegal = 1'b0;
    waiting = (state_q == S_IF) || (state_q == S_MRD) ||
              (state_q == S_MWR);
    timeout = waiting && !mem_ready && (wait_q == WAIT_MAX);
    unique case (state_q)
      S_IF: if (mem_ready) state_d = S_ID;
      S_ID: begin
        op_d = opcode;
        unique case (1'b1)
          (opcode == OP_LW) || (opcode == OP_SW):
            state_d = S_MADDR;
          opcode == OP_R:
            state_d = S_REXE;
          (opcode == OP_BEQ) || (opcode == OP_BNE):
            state_d = S_BR;
          opcode == OP_J:
            state_d = S_JMP;
`ifdef MC_CTRL_IMM_EN
          (opcode == OP_ADDI) || (opcode == OP_ANDI):
            state_d = S_IEXE;
`endif
          default: begin
            state_d = S_IF;
            illegal = 1'b1;
          end
        endcase
      end
      S_MADDR: state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
      S_MRD: if (mem_ready) state_d = S_MWB;
      S_MWB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_MWR: if (mem_ready) begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_REXE: state_d = S_RWB;
      S_RWB, S_BR, S_JMP: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
`ifdef MC_CTRL_IMM_EN
      S_IEXE: state_d = S_IWB;
      S_IWB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
`endif
      default: state_d = S_IF;
    endcase
    // a stalled access is abandoned; ready on the same cycle still wins
    if (timeout) state_d = S_IF;
    cnt_d = retire ? cnt_q + CNT_ONE : cnt_q;
    if ((state_d != state_q) || timeout) begin
      wait_d = '0;
    end else if (waiting && !mem_ready) begin
      wait_d = wait_q + WAIT_ONE;
    end else begin
      wait_d = wait_q;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_source   = 2'b00;
    unique case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: alu_src_b = 2'b11;
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BR: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_source   = 2'b01;
        pc_write_eq = (op_q == OP_BEQ);
        pc_write_ne = (op_q == OP_BNE);
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MC_CTRL_IMM_EN
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_IWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
    bus_err     = timeout;
    illegal_op  = illegal;
    state       = state_q;
    instr_count = cnt_q;
    if (rst) begin
      pc_write    = 1'b0;
      pc_write_eq = 1'b0;
      pc_write_ne = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_source   = 2'b00;
      bus_err     = 1'b0;
      illegal_op  = 1'b0;
      state       = 4'd0;
      instr_count = '0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for the multi-cycle control FSM.
// Expected state/control words are queued per cycle and popped at negedge.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ILL  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       bus_err;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_eq, pc_write_ne;
  logic        i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        bus_err, illegal_op;
  logic [31:0] instr_count;

  ctl_t        act_ctl;
  exp_t        sb[$];
  logic [5:0]  held;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .bus_err(bus_err), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  assign act_ctl = {pc_write, pc_write_eq, pc_write_ne, i_or_d,
                    mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b,
                    alu_op, pc_source, bus_err, illegal_op};

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
`ifdef MC_CTRL_IMM_EN
    return op inside {LW, SW, RT, BEQ, BNE, JMP, ADDI, ANDI};
`else
    return op inside {LW, SW, RT, BEQ, BNE, JMP};
`endif
  endfunction

  function automatic ctl_t exp_ctl(input logic [3:0] st,
                                   input logic [5:0] op,
                                   input logic rdy, input logic to);
    ctl_t c;
    c = '0;
    case (st)
      4'd0: begin
        c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = rdy;  c.pc_write  = rdy;
      end
      4'd1: begin
        c.alu_src_b = 2'b11; c.illegal_op = !legal(op);
      end
      4'd2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4'd4: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      4'd5: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      4'd6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      4'd8: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
        c.pc_write_eq = (held == BEQ); c.pc_write_ne = (held == BNE);
      end
      4'd9: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      4'd10: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = (held == ANDI) ? 2'b11 : 2'b00;
      end
      4'd11: c.reg_write = 1'b1;
      default: ;
    endcase
    c.bus_err = to;
    return c;
  endfunction

  task automatic step(input logic r, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st,
                      input logic to);
    exp_t e;
    rst = r; opcode = op; mem_ready = rdy;
    e.st = r ? 4'd0 : st;
    e.c  = r ? '0 : exp_ctl(st, op, rdy, to);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("state", 32'(state), 32'(e.st));
    chk("ctl", 32'(act_ctl), 32'(e.c));
    @(posedge clk); #1;
  endtask

  task automatic ins(input logic [5:0] op);
    held = op;
    step(1'b0, op, 1'b1, 4'd0, 1'b0);
    step(1'b0, op, 1'b1, 4'd1, 1'b0);
  endtask

  task automatic chk_cnt();
    chk("instr_count", instr_count, 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b1; held = '0;
    @(posedge clk); #1;
    step(1'b1, LW, 1'b1, 4'd0, 1'b0);
    step(1'b1, LW, 1'b1, 4'd0, 1'b0);
    chk_cnt();

    ins(LW);
    step(1'b0, LW, 1'b1, 4'd2, 1'b0);
    step(1'b0, LW, 1'b1, 4'd3, 1'b0);
    step(1'b0, LW, 1'b1, 4'd4, 1'b0);
    exp_cnt++; chk_cnt();

    ins(SW);
    step(1'b0, SW, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, SW, 1'b0, 4'd5, 1'b0);
    step(1'b0, SW, 1'b1, 4'd5, 1'b0);
    exp_cnt++; chk_cnt();

    for (int i = 0; i < 16; i++)
      step(1'b0, RT, 1'b0, 4'd0, i == 15);
    step(1'b0, RT, 1'b0, 4'd0, 1'b0);
    chk_cnt();

    ins(BEQ);
    step(1'b0, BEQ, 1'b1, 4'd8, 1'b0);
    exp_cnt++;
    ins(BNE);
    step(1'b0, BNE, 1'b1, 4'd8, 1'b0);
    exp_cnt++; chk_cnt();

    ins(JMP);
    step(1'b0, JMP, 1'b1, 4'd9, 1'b0);
    exp_cnt++;
    ins(RT);
    step(1'b0, RT, 1'b1, 4'd6, 1'b0);
    step(1'b0, RT, 1'b1, 4'd7, 1'b0);
    exp_cnt++; chk_cnt();

    ins(ILL);
    chk_cnt();

`ifdef MC_CTRL_IMM_EN
    ins(ANDI);
    step(1'b0, ANDI, 1'b1, 4'd10, 1'b0);
    step(1'b0, ANDI, 1'b1, 4'd11, 1'b0);
    exp_cnt++;
    ins(ADDI);
    step(1'b0, ADDI, 1'b1, 4'd10, 1'b0);
    step(1'b0, ADDI, 1'b1, 4'd11, 1'b0);
    exp_cnt++;
`else
    ins(ANDI);
    ins(ADDI);
`endif
    chk_cnt();

    ins(LW);
    step(1'b0, LW, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, LW, 1'b0, 4'd3, i == 15);
    chk_cnt();

    ins(SW);
    step(1'b0, SW, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, SW, 1'b0, 4'd5, 1'b0);
    step(1'b0, SW, 1'b1, 4'd5, 1'b0);
    exp_cnt++; chk_cnt();

    ins(LW);
    step(1'b0, LW, 1'b1, 4'd2, 1'b0);
    step(1'b0, LW, 1'b0, 4'd3, 1'b0);
    step(1'b1, LW, 1'b1, 4'd3, 1'b0);
    step(1'b1, LW, 1'b1, 4'd3, 1'b0);
    exp_cnt = 0;
    step(1'b0, LW, 1'b1, 4'd0, 1'b0);
    chk_cnt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
